decoupled_serializer: RTL and testbench
=======================================

Name: decoupled_serializer

Overview:
- Width-down converter directly downstream of the decoupled FIFO output port.
- Accepts DATA_WIDTH-bit words on a valid/ready input and emits them as RATIO consecutive OUT_WIDTH-bit beats on a valid/ready output.
- Typical uses: 64-bit FIFO words to byte-wide consumers (UART TX, debug port, narrow bus bridge).
- Full throughput: one beat per cycle while out_ready is high, with no bubble between words.

Parameters:
- DATA_WIDTH, 64: input word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output beat width.
- MSB_FIRST, 0: beat order. 0 = least significant slice first; 1 = most significant slice first.
- Derived localparam RATIO = DATA_WIDTH/OUT_WIDTH. Must be >= 2.
- Derived localparam CNT_WIDTH = $clog2(RATIO).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word valid (driven by FIFO ~empty).
- in_ready  output  1  serializer can take a word this cycle (drives FIFO ren).
- in_data  input  DATA_WIDTH  input word.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_WIDTH  current beat.
- busy  output  1  a word is held and beats remain; equal to out_valid.

Behaviour:
- Handshakes:
  - Input transfer: in_valid & in_ready at posedge.
  - Output transfer: out_valid & out_ready at posedge.
- State:
  - Registers: shift register shreg[DATA_WIDTH], beat counter cnt[CNT_WIDTH], out_valid register.
  - Two states, encoded by out_valid: IDLE (0) and SEND (1).
- Reset (rst high at posedge): out_valid=0, cnt=0, shreg=0, out_data=0, busy=0.
- in_ready: combinational, = ~rst & (~out_valid | (out_ready & cnt==RATIO-1)). It is 0 whenever rst is high.
- IDLE:
  - On input transfer: load shreg <= in_data, cnt <= 0, go to SEND.
  - First beat is visible on out_data the cycle after acceptance (latency 1).
- SEND, output transfer with cnt < RATIO-1:
  - cnt <= cnt+1.
  - shreg shifts by OUT_WIDTH: right if MSB_FIRST=0, left if MSB_FIRST=1. Vacated bits fill with 0.
- SEND, output transfer with cnt == RATIO-1 (last beat):
  - If in_valid is also high: reload shreg from in_data, cnt <= 0, stay in SEND (back-to-back, no bubble).
  - Otherwise: go to IDLE, out_valid <= 0, cnt <= 0.
- SEND stall (out_ready=0): shreg, cnt and out_data are held stable. out_valid must not drop.
- out_data:
  - MSB_FIRST=0: shreg[OUT_WIDTH-1:0].
  - MSB_FIRST=1: shreg[DATA_WIDTH-1:DATA_WIDTH-OUT_WIDTH].
- In IDLE, out_data holds the last shifted value. Its value is don't-care and must not be checked.
- The input is never accepted while beats of the current word remain (cnt < RATIO-1).
- Reset mid-word: the held word is discarded. out_valid is 0 in the cycle after the reset edge. No partial beats follow.
- Counter wrap: cnt compares only against RATIO-1. It never exceeds RATIO-1 even when RATIO is not a power of 2.

Optional Feature:
- Macro: SERIALIZER_LAST_EN.
- When defined:
  - Extra output port out_last (1 bit).
  - out_last = out_valid & (cnt == RATIO-1). It is held stable with out_data during stalls.
  - Reset value 0.
- When undefined: the port does not exist. All other behaviour is identical.

Test Plan:
- Reset, single word: rst 2 cycles, then in_data=64'h0807060504030201 with in_valid for 1 cycle, out_ready=1 -> in_ready=0 during reset; out_data 01,02,...,08 on 8 consecutive cycles starting 1 cycle after acceptance; out_valid falls after beat 08.
- Back-to-back: FIFO presents 64'h1111..11 then 64'h2222..22 continuously, out_ready=1 -> 16 consecutive valid beats (eight 11s, then eight 22s); in_ready high only in the IDLE cycle and on the 8th beat of each word.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly during a word -> out_data and cnt held while out_ready=0; all 8 beats appear exactly once, in order.
- MSB_FIRST=1, DATA_WIDTH=32, OUT_WIDTH=8, word 32'hAABBCCDD -> beats AA, BB, CC, DD.
- Reset mid-word: assert rst after beat 3 of 8 -> out_valid=0 the next cycle; a new word accepted after reset emits its own beats only, with none from the old word.
- SERIALIZER_LAST_EN defined, RATIO=3 (DATA_WIDTH=24, OUT_WIDTH=8): out_last=1 only on the 3rd beat, including when that beat is stalled 2 cycles.

Source files
------------

// File: rtl/decoupled_serializer.sv
// -----------------------------------------------------------------------------
// decoupled_serializer
//
// Width-down converter placed directly after a decoupled FIFO read port.
// Each DATA_WIDTH-bit word taken on the input handshake is emitted as
// RATIO = DATA_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit beats on the output
// handshake. It sustains one beat per cycle, and the next word reloads on the
// last beat so that no bubble appears between words.
//
// Parameters:
//   DATA_WIDTH  input word width (an integer multiple of OUT_WIDTH)
//   OUT_WIDTH   output beat width
//   MSB_FIRST   0: least significant slice first, 1: most significant first
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous reset, active-high
//   in_valid   input word valid (FIFO ~empty)
//   in_ready   word can be taken this cycle (FIFO ren), combinational
//   in_data    input word
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   current beat
//   out_last   (only with SERIALIZER_LAST_EN) current beat is the word's last
//   busy       a word is held and beats remain, same as out_valid
//
// Optional feature macro: SERIALIZER_LAST_EN adds the out_last port.
// -----------------------------------------------------------------------------
module decoupled_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
`ifdef SERIALIZER_LAST_EN
    output logic                  out_last,
`endif
    output logic                  busy
);

    localparam int RATIO     = DATA_WIDTH / OUT_WIDTH;
    localparam int CNT_WIDTH = $clog2(RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(RATIO - 1);

    if ((RATIO < 2) || (RATIO * OUT_WIDTH != DATA_WIDTH)) begin : g_bad_params
        $error("decoupled_serializer: DATA_WIDTH must be a multiple (>= 2x) of OUT_WIDTH");
    end

    // The state encoding is identical to out_valid.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shifted;
    logic                    last_beat;
    logic                    in_fire;
    logic                    out_fire;

    assign last_beat = (cnt_q == LAST_BEAT);
    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    // A new word is taken when idle, or in the same cycle the last beat leaves.
    assign in_ready  = ~rst & (~out_valid | (out_ready & last_beat));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // The outgoing slice always sits at the end the shift moves toward.
    assign shifted  = MSB_FIRST ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
    assign out_data = MSB_FIRST ? shreg_q[DATA_WIDTH-1 -: OUT_WIDTH]
                                : shreg_q[OUT_WIDTH-1:0];

`ifdef SERIALIZER_LAST_EN
    // Built only from registers, so it stays stable with out_data during stalls.
    assign out_last = out_valid & last_beat;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!last_beat) begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        shreg_d = shifted;
                    end else if (in_fire) begin
                        shreg_d = in_data;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: shreg is reset too so that out_data reads 0 right after reset.
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decoupled_serializer.sv
// -----------------------------------------------------------------------------
// tb_decoupled_serializer
//
// Directed bench for decoupled_serializer. Three instances share one clock:
//   u_lsb : 64/8, LSB first (reset, single word, back-to-back, backpressure,
//           reset mid-word)
//   u_msb : 32/8, MSB first
//   u_r3  : 24/8, RATIO=3, out_last checked when SERIALIZER_LAST_EN is defined
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_decoupled_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u_lsb
    logic        a_rst = 1'b1, a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_busy;
    logic [7:0]  a_out_data;
`ifdef SERIALIZER_LAST_EN
    logic        a_out_last;
`endif

    // u_msb
    logic        m_rst = 1'b1, m_in_valid = 1'b0, m_out_ready = 1'b1;
    logic [31:0] m_in_data = '0;
    logic        m_in_ready, m_out_valid, m_busy;
    logic [7:0]  m_out_data;
`ifdef SERIALIZER_LAST_EN
    logic        m_out_last;
`endif

    // u_r3
    logic        r_rst = 1'b1, r_in_valid = 1'b0, r_out_ready = 1'b1;
    logic [23:0] r_in_data = '0;
    logic        r_in_ready, r_out_valid, r_busy;
    logic [7:0]  r_out_data;
`ifdef SERIALIZER_LAST_EN
    logic        r_out_last;
`endif

    decoupled_serializer #(.DATA_WIDTH(64), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(a_rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef SERIALIZER_LAST_EN
        .out_last(a_out_last),
`endif
        .busy(a_busy)
    );

    decoupled_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(m_rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
`ifdef SERIALIZER_LAST_EN
        .out_last(m_out_last),
`endif
        .busy(m_busy)
    );

    decoupled_serializer #(.DATA_WIDTH(24), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_r3 (
        .clk(clk), .rst(r_rst),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
`ifdef SERIALIZER_LAST_EN
        .out_last(r_out_last),
`endif
        .busy(r_busy)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // One emitted beat of u_lsb: valid, busy, data and in_ready.
    task automatic check_a_beat(input string tag, input logic [7:0] data, input logic rdy);
        sample();
        check({tag, ".valid"}, 64'(a_out_valid), 64'd1);
        check({tag, ".busy"}, 64'(a_busy), 64'd1);
        check({tag, ".data"}, 64'(a_out_data), 64'(data));
        check({tag, ".in_ready"}, 64'(a_in_ready), 64'(rdy));
    endtask

    initial begin
        logic [7:0] exp_beat;
        int         idx;
        int         cyc;
        logic [3:0] bp_pattern;

        #1;
        // ---------------- Reset, single word ----------------
        a_rst = 1'b1;
        sample();
        check("rst1.in_ready", 64'(a_in_ready), 64'd0);
        advance();
        a_in_valid = 1'b1;
        a_in_data  = 64'hDEAD_BEEF_DEAD_BEEF;   // must not be accepted during reset
        sample();
        check("rst2.in_ready", 64'(a_in_ready), 64'd0);
        advance();
        a_rst      = 1'b0;
        a_in_data  = 64'h0807_0605_0403_0201;
        sample();
        check("post_rst.valid", 64'(a_out_valid), 64'd0);
        check("post_rst.busy", 64'(a_busy), 64'd0);
        check("post_rst.data", 64'(a_out_data), 64'd0);
        check("post_rst.in_ready", 64'(a_in_ready), 64'd1);
        advance();
        a_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_beat = 8'(k + 1);
            check_a_beat($sformatf("single.b%0d", k), exp_beat, k == 7);
            advance();
        end
        sample();
        check("single.end.valid", 64'(a_out_valid), 64'd0);
        check("single.end.in_ready", 64'(a_in_ready), 64'd1);

        // ---------------- Back-to-back ----------------
        advance();
        a_in_valid = 1'b1;
        a_in_data  = {8{8'h11}};
        sample();
        check("b2b.idle.in_ready", 64'(a_in_ready), 64'd1);
        advance();
        a_in_data  = {8{8'h22}};
        for (int k = 0; k < 16; k++) begin
            exp_beat = (k < 8) ? 8'h11 : 8'h22;
            check_a_beat($sformatf("b2b.b%0d", k), exp_beat, (k % 8) == 7);
            advance();
            if (k == 7) a_in_valid = 1'b0;   // second word taken on this edge
        end
        sample();
        check("b2b.end.valid", 64'(a_out_valid), 64'd0);

        // ---------------- Backpressure 1,0,0,1 ----------------
        advance();
        a_in_valid = 1'b1;
        a_in_data  = 64'h8877_6655_4433_2211;
        advance();
        a_in_valid = 1'b0;
        bp_pattern = 4'b1001;   // bit i = out_ready in cycle i mod 4
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 40) begin
            a_out_ready = bp_pattern[cyc % 4];
            exp_beat    = 8'((idx + 1) * 8'h11);
            check_a_beat($sformatf("bp.c%0d", cyc), exp_beat, a_out_ready && idx == 7);
            if (a_out_ready) idx++;
            advance();
            cyc++;
        end
        check("bp.all_beats", 64'(idx), 64'd8);
        a_out_ready = 1'b1;
        sample();
        check("bp.end.valid", 64'(a_out_valid), 64'd0);

        // ---------------- Reset mid-word ----------------
        advance();
        a_in_valid = 1'b1;
        a_in_data  = 64'hF8F7_F6F5_F4F3_F2F1;
        advance();
        a_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_beat = 8'hF1 + 8'(k);
            check_a_beat($sformatf("mid.b%0d", k), exp_beat, 1'b0);
            advance();
        end
        a_rst = 1'b1;
        sample();
        check("mid.rst.in_ready", 64'(a_in_ready), 64'd0);
        advance();
        a_rst = 1'b0;
        sample();
        check("mid.after.valid", 64'(a_out_valid), 64'd0);
        check("mid.after.busy", 64'(a_busy), 64'd0);
        advance();
        a_in_valid = 1'b1;
        a_in_data  = 64'hC8C7_C6C5_C4C3_C2C1;
        advance();
        a_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_beat = 8'hC1 + 8'(k);
            check_a_beat($sformatf("mid.new.b%0d", k), exp_beat, k == 7);
            advance();
        end
        sample();
        check("mid.new.end.valid", 64'(a_out_valid), 64'd0);

        // ---------------- MSB_FIRST, 32/8 ----------------
        advance();
        m_rst = 1'b0;
        m_in_valid = 1'b1;
        m_in_data  = 32'hAABB_CCDD;
        sample();
        check("msb.idle.in_ready", 64'(m_in_ready), 64'd1);
        advance();
        m_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_beat = 8'hAA + 8'(k * 8'h11);
            sample();
            check($sformatf("msb.b%0d.valid", k), 64'(m_out_valid), 64'd1);
            check($sformatf("msb.b%0d.data", k), 64'(m_out_data), 64'(exp_beat));
            check($sformatf("msb.b%0d.in_ready", k), 64'(m_in_ready), 64'(k == 3));
            advance();
        end
        sample();
        check("msb.end.valid", 64'(m_out_valid), 64'd0);

        // ---------------- RATIO=3 with last-beat stall ----------------
        advance();
        r_rst = 1'b0;
        r_in_valid = 1'b1;
        r_in_data  = 24'h33_2211;
`ifdef SERIALIZER_LAST_EN
        sample();
        check("r3.idle.last", 64'(r_out_last), 64'd0);
`endif
        advance();
        r_in_valid = 1'b0;
        // cycles: beat 11, beat 22, beat 33 stalled twice, beat 33 accepted
        for (int c = 0; c < 5; c++) begin
            r_out_ready = !(c == 2 || c == 3);
            exp_beat    = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
            sample();
            check($sformatf("r3.c%0d.valid", c), 64'(r_out_valid), 64'd1);
            check($sformatf("r3.c%0d.data", c), 64'(r_out_data), 64'(exp_beat));
            check($sformatf("r3.c%0d.in_ready", c), 64'(r_in_ready), 64'(c == 4));
`ifdef SERIALIZER_LAST_EN
            check($sformatf("r3.c%0d.last", c), 64'(r_out_last), 64'(c >= 2));
`endif
            advance();
        end
        r_out_ready = 1'b1;
        sample();
        check("r3.end.valid", 64'(r_out_valid), 64'd0);
`ifdef SERIALIZER_LAST_EN
        check("r3.end.last", 64'(r_out_last), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
